// File: rtl/rx_bit_timer.sv
// UART receive bit-timing controller: mid-bit strobes for start, data, stop
// (and optional parity) bits with abort, busy and bit-index reporting.
// Optional parity bit enabled by defining RX_BIT_TIMER_PARITY_EN.
module rx_bit_timer #(
  parameter int unsigned CNT_W    = 14,
  parameter int unsigned MAX_BITS = 8,
  parameter int unsigned IDX_W    = $clog2(MAX_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_timer,
  input  logic             abort,
  input  logic [CNT_W-1:0] bit_period,
  input  logic [IDX_W-1:0] data_size,
  input  logic             two_stop,
`ifdef RX_BIT_TIMER_PARITY_EN
  input  logic             parity_on,
  output logic             parity_sample,
`endif
  output logic             start_sample,
  output logic             shift_enable,
  output logic             stop_sample,
  output logic             packet_done,
  output logic             busy,
  output logic [IDX_W-1:0] bit_index
);

`ifdef RX_BIT_TIMER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] per_q, half_q;
  logic [IDX_W-1:0] dsz_q;
  logic             two_q;
  logic             stop_q;
`ifdef RX_BIT_TIMER_PARITY_EN
  logic             par_q;
`endif

  logic [CNT_W-1:0] per_c;
  logic [IDX_W-1:0] dsz_c;
  logic             tick_c;
  logic             last_data_c;
  logic             last_stop_c;
  logic             frame_start_c;

  // Clamp the requested configuration to legal values
  always_comb begin
    per_c = (bit_period < CNT_W'(2)) ? CNT_W'(2) : bit_period;
    if (data_size == IDX_W'(0))
      dsz_c = IDX_W'(1);
    else if (data_size > IDX_W'(MAX_BITS))
      dsz_c = IDX_W'(MAX_BITS);
    else
      dsz_c = data_size;
  end

  // Period-counter terminal count and frame-position decodes
  always_comb begin
    tick_c = 1'b0;
    unique case (state_q)
      START:   tick_c = (cnt_q == half_q);
      IDLE:    tick_c = 1'b0;
      default: tick_c = (cnt_q == per_q);
    endcase
    tick_c        = tick_c & ~abort;
    last_data_c   = (bit_index == IDX_W'(dsz_q - IDX_W'(1)));
    last_stop_c   = ~two_q | stop_q;
    frame_start_c = (state_q == IDLE) & enable_timer;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (enable_timer) state_d = START;
    end else if (abort) begin
      state_d = IDLE;
    end else if (tick_c) begin
      unique case (state_q)
        START: state_d = DATA;
`ifdef RX_BIT_TIMER_PARITY_EN
        DATA:   if (last_data_c) state_d = par_q ? PARITY : STOP;
        PARITY: state_d = STOP;
`else
        DATA:  if (last_data_c) state_d = STOP;
`endif
        STOP:  if (last_stop_c) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from state and the period counter
  always_comb begin
    start_sample  = (state_q == START) & tick_c;
    shift_enable  = (state_q == DATA) & tick_c;
    stop_sample   = (state_q == STOP) & tick_c;
    packet_done   = stop_sample & last_stop_c;
    busy          = (state_q != IDLE);
`ifdef RX_BIT_TIMER_PARITY_EN
    parity_sample = (state_q == PARITY) & tick_c;
`endif
  end

  // Configuration latch, period counter, bit index and stop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      per_q     <= '0;
      half_q    <= '0;
      dsz_q     <= '0;
      two_q     <= 1'b0;
      stop_q    <= 1'b0;
      bit_index <= '0;
`ifdef RX_BIT_TIMER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else if (frame_start_c) begin
      per_q     <= per_c;
      half_q    <= per_c >> 1;
      dsz_q     <= dsz_c;
      two_q     <= two_stop;
      cnt_q     <= CNT_W'(1);
      stop_q    <= 1'b0;
      bit_index <= '0;
`ifdef RX_BIT_TIMER_PARITY_EN
      par_q     <= parity_on;
`endif
    end else if (state_d == IDLE) begin
      cnt_q     <= '0;
      stop_q    <= 1'b0;
      bit_index <= '0;
    end else begin
      cnt_q <= tick_c ? CNT_W'(1) : CNT_W'(cnt_q + CNT_W'(1));
      if (shift_enable) bit_index <= IDX_W'(bit_index + IDX_W'(1));
      if (stop_sample)  stop_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer: per-cycle strobe/busy/bit_index vectors
// compared against hand-derived frame timing.
module tb_rx_bit_timer;

  localparam int unsigned CNT_W = 14;
  localparam int unsigned IDX_W = 4;
  localparam int NMAX = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable_timer;
  logic             abort;
  logic [CNT_W-1:0] bit_period;
  logic [IDX_W-1:0] data_size;
  logic             two_stop;
  logic             parity_on;
  logic             par_s;
  logic             start_sample, shift_enable, stop_sample, packet_done, busy;
  logic [IDX_W-1:0] bit_index;

  int vectors = 0;
  int miscompares = 0;

  // {parity, start, shift, stop, done, busy, bit_index}
  logic [9:0] obs   [0:NMAX-1];
  logic [9:0] exp_v [0:NMAX-1];

  rx_bit_timer dut (
    .clk          (clk),
    .rst          (rst),
    .enable_timer (enable_timer),
    .abort        (abort),
    .bit_period   (bit_period),
    .data_size    (data_size),
    .two_stop     (two_stop),
`ifdef RX_BIT_TIMER_PARITY_EN
    .parity_on    (parity_on),
    .parity_sample(par_s),
`endif
    .start_sample (start_sample),
    .shift_enable (shift_enable),
    .stop_sample  (stop_sample),
    .packet_done  (packet_done),
    .busy         (busy),
    .bit_index    (bit_index)
  );

`ifndef RX_BIT_TIMER_PARITY_EN
  assign par_s = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [9:0] snap();
    return {par_s, start_sample, shift_enable, stop_sample, packet_done, busy, bit_index};
  endfunction

  task automatic clear_exp();
    for (int c = 0; c < NMAX; c++) exp_v[c] = '0;
  endtask

  // Expected timing of one frame whose enable is sampled in cycle base
  task automatic add_frame(input int base, input int p, input int d, input int s,
                           input int par, input int abort_cyc);
    int h, last, cut, k;
    h    = p / 2;
    last = base + h + (d + par + s) * p;
    cut  = (abort_cyc < 0) ? NMAX : abort_cyc;
    for (int c = base + 1; c <= last && c <= cut && c < NMAX; c++) begin
      exp_v[c][4] = 1'b1;
      k = 0;
      for (int i = 1; i <= d; i++) if (base + h + i * p < c) k++;
      exp_v[c][3:0] = 4'(k);
    end
    if (base + h < cut) exp_v[base + h][8] = 1'b1;
    for (int i = 1; i <= d; i++)
      if (base + h + i * p < cut) exp_v[base + h + i * p][7] = 1'b1;
    if (par == 1 && base + h + (d + 1) * p < cut) exp_v[base + h + (d + 1) * p][9] = 1'b1;
    for (int j = 1; j <= s; j++)
      if (base + h + (d + par + j) * p < cut) exp_v[base + h + (d + par + j) * p][6] = 1'b1;
    if (last < cut) exp_v[last][5] = 1'b1;
  endtask

  // Run ncyc cycles with frame enable at cycle 0 and optional disturbances
  task automatic capture(input int ncyc, input int per, input int dsz, input logic two,
                         input logic par, input int abort_cyc, input int retrig_cyc,
                         input int en2_cyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      enable_timer = (c == 0) || (c == retrig_cyc) || (c == en2_cyc);
      abort        = (c == abort_cyc);
      bit_period   = (retrig_cyc >= 0 && c >= retrig_cyc && c < retrig_cyc + 30) ?
                     CNT_W'(4) : CNT_W'(per);
      data_size    = IDX_W'(dsz);
      two_stop     = two;
      parity_on    = par;
      #1;
      obs[c] = snap();
    end
    @(negedge clk);
    enable_timer = 1'b0;
    abort        = 1'b0;
  endtask

  task automatic compare_run(input string name, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      vectors++;
      if (obs[c] !== exp_v[c]) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got par/st/sh/sp/dn/bsy/idx=%b required %b",
                 name, c, obs[c], exp_v[c]);
      end
    end
  endtask

  // Idle for a few cycles so each scenario starts from IDLE
  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] v;
    @(negedge clk);
    rst = 1'b1; enable_timer = 1'b0; abort = 1'b0;
    bit_period = CNT_W'(10); data_size = IDX_W'(8); two_stop = 1'b0; parity_on = 1'b0;
    repeat (2) @(negedge clk);
    #1; v = snap();
    vectors++;
    if (v !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b required %b", v, 10'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    // start a frame and reset it mid-way: must fall silently to IDLE
    enable_timer = 1'b1;
    @(negedge clk);
    enable_timer = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1; v = snap();
    vectors++;
    if (v !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_midframe: got %b required %b", v, 10'b0);
    end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (packet_done !== 1'b0 || busy !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL reset_no_done cycle %0d: got done=%b busy=%b required 0 0",
                 c, packet_done, busy);
      end
    end
    vectors++;
    settle();
  endtask

  task automatic test_basic();
    clear_exp(); add_frame(0, 10, 8, 1, 0, -1);
    capture(100, 10, 8, 1'b0, 1'b0, -1, -1, -1);
    compare_run("basic", 100);
    settle();
  endtask

  task automatic test_two_stop();
    clear_exp(); add_frame(0, 10, 8, 2, 0, -1);
    capture(110, 10, 8, 1'b1, 1'b0, -1, -1, -1);
    compare_run("two_stop", 110);
    settle();
  endtask

  task automatic test_abort();
    clear_exp(); add_frame(0, 10, 8, 1, 0, 40);
    capture(100, 10, 8, 1'b0, 1'b0, 40, -1, -1);
    compare_run("abort", 100);
    // abort landing on a strobe cycle suppresses that strobe
    clear_exp(); add_frame(0, 10, 8, 1, 0, 45);
    capture(60, 10, 8, 1'b0, 1'b0, 45, -1, -1);
    compare_run("abort_on_strobe", 60);
    settle();
  endtask

  task automatic test_back_to_back();
    clear_exp(); add_frame(0, 10, 8, 1, 0, -1); add_frame(96, 10, 8, 1, 0, -1);
    capture(200, 10, 8, 1'b0, 1'b0, -1, 30, 96);
    compare_run("retrigger_back_to_back", 200);
    settle();
  endtask

  task automatic test_clamp();
    clear_exp(); add_frame(0, 2, 1, 1, 0, -1);
    capture(10, 1, 0, 1'b0, 1'b0, -1, -1, -1);
    compare_run("clamp_min", 10);
    settle();
    clear_exp(); add_frame(0, 10, 8, 1, 0, -1);
    capture(100, 10, 15, 1'b0, 1'b0, -1, -1, -1);
    compare_run("clamp_dmax", 100);
    settle();
  endtask

`ifdef RX_BIT_TIMER_PARITY_EN
  task automatic test_parity();
    clear_exp(); add_frame(0, 10, 8, 1, 1, -1);
    capture(110, 10, 8, 1'b0, 1'b1, -1, -1, -1);
    compare_run("parity_on", 110);
    settle();
    clear_exp(); add_frame(0, 10, 8, 1, 0, -1);
    capture(100, 10, 8, 1'b0, 1'b0, -1, -1, -1);
    compare_run("parity_off", 100);
    settle();
  endtask
`endif

  initial begin
    rst = 1'b1; enable_timer = 1'b0; abort = 1'b0;
    bit_period = '0; data_size = '0; two_stop = 1'b0; parity_on = 1'b0;
    test_reset();
    test_basic();
    test_two_stop();
    test_abort();
    test_back_to_back();
    test_clamp();
`ifdef RX_BIT_TIMER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
Parametrised bit-timing controller for the UART receive path of the APB slave peripheral. It takes a start trigger from the start-bit detector and produces strobes at the centre of every bit: start, data, optional parity, and one or two stop bits. The shift register and stop/parity checkers consume these strobes. It is a single FSM with a bit-period counter and a bit counter. Relative to the previous timer it adds mid-bit alignment, configurable stop bits, abort, busy and bit-index outputs, and input clamping.

Parameters:
CNT_W, 14, width of the bit-period counter and of bit_period.
MAX_BITS, 8, maximum data bits per frame.
IDX_W, $clog2(MAX_BITS+1), width of data_size and bit_index.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
enable_timer  input  1  start trigger from the start-bit detector; sampled only in IDLE
abort  input  1  cancels the frame in progress (e.g. false start)
bit_period  input  CNT_W  clocks per bit
data_size  input  IDX_W  data bits per frame
two_stop  input  1  0 selects 1 stop bit; 1 selects 2 stop bits
start_sample  output  1  1-cycle strobe at the start-bit centre
shift_enable  output  1  1-cycle strobe at each data-bit centre
stop_sample  output  1  1-cycle strobe at each stop-bit centre
packet_done  output  1  1-cycle pulse, frame complete
busy  output  1  high while not in IDLE
bit_index  output  IDX_W  number of data bits strobed so far in the current frame

Behaviour:
- States: IDLE, START, DATA, STOP (plus PARITY when the optional feature is compiled in).
- Reset (rst=1 at a clock edge): next state IDLE, counters 0, bit_index 0, every output 0. Reset mid-frame aborts silently; packet_done is not pulsed.
- Configuration is latched on the IDLE-to-START edge and is stable for the whole frame; input changes mid-frame are ignored.
  - P = max(bit_period, 2).
  - D = data_size clamped to the range 1..MAX_BITS.
  - S = two_stop ? 2 : 1.
  - H = P>>1 (always at least 1).
- Cycle 0 is the cycle in which enable_timer=1 is sampled in IDLE. The FSM enters START at the next edge.
- Strobe timing:
  - start_sample is high in cycle H.
  - The k-th shift_enable (k = 1..D) is high in cycle H + k*P.
  - The j-th stop_sample (j = 1..S) is high in cycle H + (D + j)*P.
- The period counter counts 1..target and reloads to 1 in the cycle its strobe fires, so there are no dead cycles between bits.
- bit_index increments in the cycle after each shift_enable. It holds D through STOP and clears when the FSM returns to IDLE.
- packet_done is high in the same cycle as the final stop_sample. The FSM is in IDLE with busy=0 in the next cycle, and a new enable_timer is accepted in that IDLE cycle.
- enable_timer while busy=1 is ignored (no restart, no queueing).
- abort=1 in any non-IDLE state: IDLE at the next edge, and no strobe or packet_done in the abort cycle. In IDLE, abort has no effect.
- If abort and enable_timer are both high in IDLE, abort is ignored and the frame starts.
- At most one of start_sample, shift_enable and stop_sample is high in any cycle.

Optional Feature:
Macro RX_BIT_TIMER_PARITY_EN.
- When defined:
  - Adds input parity_on (1 bit), latched with the rest of the configuration.
  - Adds output parity_sample (1-cycle strobe).
  - With parity_on=1, parity_sample is high in cycle H + (D+1)*P. Stop strobes shift to H + (D+1+j)*P, and packet_done moves with them.
- When undefined: no parity_on or parity_sample ports and no PARITY state; timing is as in Behaviour.

Test Plan:
1. Basic frame: rst, then P=10, D=8, two_stop=0, pulse enable_timer at cycle 0.
   - start_sample at 5.
   - shift_enable at 15, 25, ..., 85.
   - stop_sample and packet_done at 95; busy=0 at 96.
   - bit_index=8 from 86.
2. Two stop bits: same setup with two_stop=1.
   - stop_sample at 95 and 105; packet_done only at 105.
3. Abort: frame as in 1, abort=1 at cycle 40.
   - No strobes from 40 on; busy=0 at 41; no packet_done; bit_index=0 at 41.
4. Retrigger and changes while busy:
   - enable_timer re-pulsed at 30 and bit_period changed to 4 at 30: timing is unchanged from scenario 1.
   - New enable at 96 gives start_sample at 101.
5. Clamping:
   - P=1, D=0: behaves as P=2, D=1, so start_sample at 1, shift_enable at 3, stop_sample/packet_done at 5.
   - D=15: clamped to 8 data strobes.
6. Parity (macro defined, parity_on=1, P=10, D=8):
   - parity_sample at 95; stop_sample/packet_done at 105.
   - Same frame with parity_on=0 matches scenario 1.
